// File: rtl/risc_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC[/MEM] per instruction, 16-word program space.
// Optional single-step mode (PAUSE state and step input) is enabled by defining RISC_SEQ_SINGLE_STEP_EN.
module risc_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
`ifdef RISC_SEQ_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic [3:0]  imaddr,
  input  logic [15:0] imdata,
  output logic [3:0]  opcode,
  output logic [2:0]  dstin,
  output logic [2:0]  opnda_addr,
  output logic [2:0]  opndb_addr,
  output logic [3:0]  dmaddrin,
  output logic        busy,
  output logic        done,
  output logic [7:0]  retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4
`ifdef RISC_SEQ_SINGLE_STEP_EN
    , PAUSE = 3'd5
`endif
  } state_t;

  state_t      state_r;
  logic [3:0]  pc_r;
  logic [15:0] ir_r;
  logic [3:0]  opcode_r;
  logic        busy_r;
  logic        done_r;
  logic        stop_pend_r;
  logic [7:0]  retired_r;
  logic        is_mem_s;
  logic        boundary_s;
  logic        halt_s;
  logic        unused_rsvd_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) sat_inc8 = 8'hFF;
    else            sat_inc8 = v + 8'd1;
  endfunction

  // Instruction boundary detection and halt decision
  always_comb begin
    is_mem_s   = (ir_r[15:13] == 3'b111);
    boundary_s = 1'b0;
    if (state_r == MEM)       boundary_s = 1'b1;
    else if (state_r == EXEC) boundary_s = !is_mem_s;
    else                      boundary_s = 1'b0;
    halt_s = stop_pend_r | stop | (pc_r == 4'hF);
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pc_r        <= 4'h0;
      ir_r        <= 16'h0000;
      opcode_r    <= 4'h0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      stop_pend_r <= 1'b0;
      retired_r   <= 8'h00;
    end else begin
      done_r <= 1'b0;
      if ((state_r != IDLE) && stop) stop_pend_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (start && !stop) begin
            state_r   <= FETCH;
            busy_r    <= 1'b1;
            pc_r      <= 4'h0;
            retired_r <= 8'h00;
          end
        end
        FETCH:  state_r <= DECODE;
        DECODE: begin
          // Opcode is loaded straight from imdata so it is valid throughout EXEC
          ir_r     <= imdata;
          opcode_r <= imdata[15:12];
          state_r  <= EXEC;
        end
        EXEC: begin
          if (is_mem_s) state_r <= MEM;
        end
        MEM: state_r <= MEM;
`ifdef RISC_SEQ_SINGLE_STEP_EN
        PAUSE: begin
          if (stop) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            stop_pend_r <= 1'b0;
          end else if (step) begin
            state_r <= FETCH;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      if (boundary_s) begin
        retired_r <= sat_inc8(retired_r);
        pc_r      <= pc_r + 4'h1;
        opcode_r  <= 4'h0;
        if (halt_s) begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
          stop_pend_r <= 1'b0;
        end else begin
`ifdef RISC_SEQ_SINGLE_STEP_EN
          state_r <= PAUSE;
`else
          state_r <= FETCH;
`endif
        end
      end
    end
  end

  // Address fields come straight from ir, which holds until the next DECODE
  assign imaddr        = pc_r;
  assign opcode        = opcode_r;
  assign dstin         = ir_r[11:9];
  assign opnda_addr    = ir_r[11:9];
  assign opndb_addr    = ir_r[8:6];
  assign dmaddrin      = ir_r[3:0];
  assign busy          = busy_r;
  assign done          = done_r;
  assign retired       = retired_r;
  assign unused_rsvd_s = ^ir_r[5:4];

endmodule

// File: tb/tb_risc_seq.sv
// Directed, table-driven bench for risc_seq with a registered instruction memory model.
module tb_risc_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, stop;
`ifdef RISC_SEQ_SINGLE_STEP_EN
  logic        step;
`endif
  logic [3:0]  imaddr;
  logic [15:0] imdata;
  logic [3:0]  opcode;
  logic [2:0]  dstin, opnda_addr, opndb_addr;
  logic [3:0]  dmaddrin;
  logic        busy, done;
  logic [7:0]  retired;
  logic [15:0] imem [16];
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    logic [15:0] word;
    logic [3:0]  op;
    logic [2:0]  da;
    logic [2:0]  db;
    logic [3:0]  dm;
    bit          is_mem;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;
  always @(posedge clk) imdata <= imem[imaddr];

  risc_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
`ifdef RISC_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .imaddr(imaddr), .imdata(imdata), .opcode(opcode), .dstin(dstin),
    .opnda_addr(opnda_addr), .opndb_addr(opndb_addr), .dmaddrin(dmaddrin),
    .busy(busy), .done(done), .retired(retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_alu();
    for (int i = 0; i < 16; i++)
      imem[i] = {4'(1 + i % 13), 3'(i), 3'(i + 1), 2'b00, 4'(i)};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, t2, t3, fcnt, seen;
    vecs[0] = '{16'h1E00, 4'h1, 3'd7, 3'd0, 4'h0, 1'b0};
    vecs[1] = '{16'h0000, 4'h0, 3'd0, 3'd0, 4'h0, 1'b0};
    vecs[2] = '{16'hE2C9, 4'hE, 3'd1, 3'd3, 4'h9, 1'b1};
    vecs[3] = '{16'hF005, 4'hF, 3'd0, 3'd0, 4'h5, 1'b1};
    vecs[4] = '{16'hDB7A, 4'hD, 3'd5, 3'd5, 4'hA, 1'b0};
    for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
`ifdef RISC_SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    #2;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst opcode", opcode, 0);
    chk("rst retired", retired, 0);
    chk("rst imaddr", imaddr, 0);
    chk("rst dst/opnd", {dstin, opnda_addr, opndb_addr, dmaddrin}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    start = 1'b1; stop = 1'b1;
    tick();
    chk("start+stop stays idle", busy, 0);
    start = 1'b0; stop = 1'b0;

    // Single-instruction decode vectors, halted via stop during FETCH
    for (int v = 0; v < 5; v++) begin
      do_reset();
      imem[0] = vecs[v].word;
      start_run();
      chk($sformatf("v%0d fetch busy", v), busy, 1);
      chk($sformatf("v%0d fetch opcode", v), opcode, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk($sformatf("v%0d decode opcode", v), opcode, 0);
      tick();
      chk($sformatf("v%0d exec opcode", v), opcode, vecs[v].op);
      chk($sformatf("v%0d exec dstin", v), dstin, vecs[v].da);
      chk($sformatf("v%0d exec opnda", v), opnda_addr, vecs[v].da);
      chk($sformatf("v%0d exec opndb", v), opndb_addr, vecs[v].db);
      chk($sformatf("v%0d exec dmaddr", v), dmaddrin, vecs[v].dm);
      if (vecs[v].is_mem) begin
        tick();
        chk($sformatf("v%0d mem opcode", v), opcode, vecs[v].op);
        chk($sformatf("v%0d mem dmaddr", v), dmaddrin, vecs[v].dm);
      end
      tick();
      chk($sformatf("v%0d done", v), done, 1);
      chk($sformatf("v%0d busy", v), busy, 0);
      chk($sformatf("v%0d retired", v), retired, 1);
      chk($sformatf("v%0d pc", v), imaddr, 1);
      chk($sformatf("v%0d idle opcode", v), opcode, 0);
      chk($sformatf("v%0d dmaddr held", v), dmaddrin, vecs[v].dm);
      tick();
      chk($sformatf("v%0d done pulse", v), done, 0);
    end

`ifndef RISC_SEQ_SINGLE_STEP_EN
    // Full 16-word ALU program, with an ignored start while busy
    do_reset();
    load_alu();
    start_run();
    cnt = 0;
    while (!done && cnt < 200) begin
      if (cnt == 5) start = 1'b1;
      tick();
      start = 1'b0;
      cnt++;
    end
    chk("prog16 cycles", cnt, 48);
    chk("prog16 retired", retired, 16);
    chk("prog16 pc", imaddr, 0);
    chk("prog16 busy", busy, 0);
    tick();
    chk("prog16 done pulse", done, 0);
    chk("prog16 stays idle", busy, 0);

    // ST at pc=2: two-cycle hold and 4-cycle spacing
    do_reset();
    load_alu();
    imem[2] = 16'hF005;
    start_run();
    t2 = -1; t3 = -1; fcnt = 0;
    for (int c = 1; c <= 60 && !done; c++) begin
      tick();
      if (imaddr == 4'd2 && t2 < 0) t2 = c;
      if (imaddr == 4'd3 && t3 < 0) begin
        t3 = c;
        stop = 1'b1;
      end else begin
        stop = 1'b0;
      end
      if (opcode == 4'hF && dmaddrin == 4'h5) fcnt++;
    end
    stop = 1'b0;
    chk("st fetch time", t2, 6);
    chk("st spacing", t3 - t2, 4);
    chk("st hold cycles", fcnt, 2);
    chk("st done", done, 1);
    chk("st retired", retired, 4);

    // Stop during DECODE of instruction 3
    do_reset();
    load_alu();
    start_run();
    repeat (10) tick();
    chk("stopdec pc", imaddr, 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stopdec exec busy", busy, 1);
    chk("stopdec exec opcode", opcode, 4);
    tick();
    chk("stopdec done", done, 1);
    chk("stopdec busy", busy, 0);
    chk("stopdec retired", retired, 4);
    chk("stopdec pc after", imaddr, 4);
    tick();
    chk("stopdec done pulse", done, 0);

    // Reset during EXEC, then restart
    do_reset();
    load_alu();
    imem[0] = 16'h1E00;
    start_run();
    tick();
    tick();
    chk("cyc3 opcode", opcode, 1);
    chk("cyc3 opnda", opnda_addr, 7);
    chk("cyc3 opndb", opndb_addr, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst opcode", opcode, 0);
    chk("midrst opnda", opnda_addr, 0);
    chk("midrst busy", busy, 0);
    chk("midrst pc", imaddr, 0);
    seen = 0;
    repeat (3) begin
      tick();
      if (done) seen++;
    end
    chk("midrst no done", seen, 0);
    chk("midrst retired", retired, 0);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart busy", busy, 1);
    chk("restart pc", imaddr, 0);
    tick();
    tick();
    chk("restart opcode", opcode, 1);
    tick();
    chk("restart retired", retired, 1);
    chk("restart pc inc", imaddr, 1);
`else
    // Single-step: PAUSE after each instruction until step or stop
    do_reset();
    imem[0] = 16'h1E00;
    imem[1] = 16'h2240;
    start_run();
    repeat (3) tick();
    chk("pause busy", busy, 1);
    chk("pause opcode", opcode, 0);
    chk("pause pc", imaddr, 1);
    chk("pause retired", retired, 1);
    repeat (3) tick();
    chk("pause hold busy", busy, 1);
    chk("pause hold pc", imaddr, 1);
    chk("pause hold retired", retired, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step fetch pc", imaddr, 1);
    tick();
    tick();
    chk("step exec opcode", opcode, 2);
    tick();
    chk("step retired", retired, 2);
    step = 1'b1;
    stop = 1'b1;
    tick();
    step = 1'b0;
    stop = 1'b0;
    chk("pause stop done", done, 1);
    chk("pause stop busy", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
